// File: rtl/zoned_mult_pkg.sv
// Shared types and helpers for the zoned approximate multiplier pipeline.
// Holds the operation mode encoding, the low-bit truncation helper and the parameter sanity check.
package zoned_mult_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_ZONED = 2'd1,
    MODE_TRUNC = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  // Partial products are never wider than this, which bounds W at 64.
  localparam int unsigned PP_MAX = 64;

  // Clear the n least significant bits of x.
  function automatic logic [PP_MAX-1:0] trunc_low(input logic [PP_MAX-1:0] x,
                                                  input int unsigned        n);
    logic [PP_MAX-1:0] keep;
    keep = ~((64'd1 << n) - 64'd1);
    return x & keep;
  endfunction

  // Reserved encoding computes and reports as exact.
  function automatic mode_t norm_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_ZONED;
      2'd2:    return MODE_TRUNC;
      default: return MODE_EXACT;
    endcase
  endfunction

  function automatic bit cfg_ok(input int w, input int lsb_trunc,
                                input int mid_trunc, input int cw);
    return (w >= 8) && (w <= int'(PP_MAX)) && ((w % 2) == 0) &&
           (lsb_trunc >= 0) && (lsb_trunc <= w / 2) &&
           (mid_trunc >= 0) && (mid_trunc <= w / 2) &&
           (cw >= 1);
  endfunction

endpackage

// File: rtl/zone_pp_gen.sv
// Combinational generator of the four HxH zone partial products.
// Each product is 2H bits wide so no carries are lost before the combine stage.
module zone_pp_gen #(
  parameter int H = 8
) (
  input  logic [H-1:0]   a_lo,
  input  logic [H-1:0]   a_hi,
  input  logic [H-1:0]   b_lo,
  input  logic [H-1:0]   b_hi,
  output logic [2*H-1:0] ll,
  output logic [2*H-1:0] lh,
  output logic [2*H-1:0] hl,
  output logic [2*H-1:0] hh
);

  localparam int PW = 2 * H;

  assign ll = PW'(a_lo) * PW'(b_lo);
  assign lh = PW'(a_lo) * PW'(b_hi);
  assign hl = PW'(a_hi) * PW'(b_lo);
  assign hh = PW'(a_hi) * PW'(b_hi);

endmodule

// File: rtl/zoned_approx_mult_pipe.sv
// Three-stage valid/ready multiplier with exact, zoned-approximate and truncated modes.
// S1 registers operands, S2 registers zone partial products, S3 combines per mode into out_p.
module zoned_approx_mult_pipe
  import zoned_mult_pkg::*;
#(
  parameter int W         = 16,
  parameter int LSB_TRUNC = 4,
  parameter int MID_TRUNC = 2,
  parameter int CW        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_p,
  output logic [1:0]      out_mode,
  output logic [CW-1:0]   approx_count
);

  localparam int H  = W / 2;
  localparam int PW = 2 * W;

  if (!cfg_ok(W, LSB_TRUNC, MID_TRUNC, CW)) begin : g_cfg_err
    $error("zoned_approx_mult_pipe: illegal W/LSB_TRUNC/MID_TRUNC/CW combination");
  end

  // Whole pipe moves together; it only stalls when a finished product is waiting.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  mode_t        s1_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_EXACT;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= norm_mode(in_mode);
      end
    end
  end

  logic [W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  zone_pp_gen #(.H(H)) u_pp_gen (
    .a_lo (s1_a[H-1:0]),
    .a_hi (s1_a[W-1:H]),
    .b_lo (s1_b[H-1:0]),
    .b_hi (s1_b[W-1:H]),
    .ll   (pp_ll),
    .lh   (pp_lh),
    .hl   (pp_hl),
    .hh   (pp_hh)
  );

  logic         s2_valid;
  logic [W-1:0] s2_ll, s2_lh, s2_hl, s2_hh;
  mode_t        s2_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_ll    <= '0;
      s2_lh    <= '0;
      s2_hl    <= '0;
      s2_hh    <= '0;
      s2_mode  <= MODE_EXACT;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ll   <= pp_ll;
        s2_lh   <= pp_lh;
        s2_hl   <= pp_hl;
        s2_hh   <= pp_hh;
        s2_mode <= s1_mode;
      end
    end
  end

  logic [PW-1:0] full_p;
  logic [W-1:0]  ll_t, lh_t, hl_t;
  logic [PW-1:0] zone_sum;
  logic [PW-1:0] comb_p;

  // The zoned low half is summed at full 2W width and cut to W, so the
  // high half always comes from the exact product.
  always_comb begin
    full_p   = (PW'(s2_hh) << W) + ((PW'(s2_lh) + PW'(s2_hl)) << H) + PW'(s2_ll);
    ll_t     = W'(trunc_low(64'(s2_ll), LSB_TRUNC));
    lh_t     = W'(trunc_low(64'(s2_lh), MID_TRUNC));
    hl_t     = W'(trunc_low(64'(s2_hl), MID_TRUNC));
    zone_sum = PW'(ll_t) + ((PW'(lh_t) + PW'(hl_t)) << H);
    comb_p   = full_p;
    case (s2_mode)
      MODE_ZONED: comb_p = {full_p[PW-1:W], zone_sum[W-1:0]};
      MODE_TRUNC: comb_p = {full_p[PW-1:W], {W{1'b0}}};
      default:    comb_p = full_p;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_mode  <= MODE_EXACT;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_p    <= comb_p;
        out_mode <= s2_mode;
      end
    end
  end

  logic out_xfer_approx;
  assign out_xfer_approx = out_valid && out_ready &&
                           ((out_mode == MODE_ZONED) || (out_mode == MODE_TRUNC));

  always_ff @(posedge clk) begin
    if (rst) begin
      approx_count <= '0;
    end else if (out_xfer_approx && (approx_count != {CW{1'b1}})) begin
      approx_count <= approx_count + 1'b1;
    end
  end

endmodule

// File: doc/zoned_approx_mult_pipe.md
Name: zoned_approx_mult_pipe

Overview:
Parametrised, pipelined successor to the fixed 16-bit three-zone multiplier. Takes W-bit unsigned operands and a per-operation mode (exact, zoned-approximate, truncated). Produces a 2W-bit product through a 3-stage valid/ready pipeline with backpressure. Sits in the datapath as a drop-in multiplier wherever throughput and a runtime accuracy/energy trade-off are needed.

Parameters:
W, 16, operand width; even, >= 8; H = W/2 is the zone half-width.
LSB_TRUNC, 4, low bits zeroed in the LL (low×low) zone product in zoned mode; 0..H.
MID_TRUNC, 2, low bits zeroed in each cross-zone product (LH, HL) in zoned mode; 0..H.
CW, 16, width of the approximate-operation counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  operand beat valid.
in_ready  out  1  pipeline can accept a beat.
in_a  in  W  operand A, unsigned.
in_b  in  W  operand B, unsigned.
in_mode  in  2  0 = EXACT, 1 = ZONED, 2 = TRUNC, 3 = reserved (treated as EXACT).
out_valid  out  1  product beat valid.
out_ready  in  1  downstream accepts the beat.
out_p  out  2W  product.
out_mode  out  2  mode the product was computed with (3 reported as 0).
approx_count  out  CW  count of delivered ZONED/TRUNC results; saturating.

Behaviour:
- Reset (synchronous, rst high at a clk edge): all stage valids = 0; out_valid = 0, out_p = 0, out_mode = 0, approx_count = 0. in_ready = 1 the cycle after reset. Any in-flight beats are discarded.
- Pipeline: S1 registers a, b, mode. S2 registers the four H×H partial products: LL = aL·bL, LH = aL·bH, HL = aH·bL, HH = aH·bH. S3 combines the partial products per mode and drives out_p.
- Latency: 3 cycles from an accepted input beat to out_valid, when not stalled. Throughput is 1 beat/cycle.
- Handshake: a beat transfers on valid && ready. Global advance enable is en = !out_valid || out_ready. in_ready = en, combinational. When en = 0, all stages hold. Bubbles propagate as valid = 0. out_p and out_mode stay stable while out_valid && !out_ready.
- Arithmetic, with F = exact full product = (HH<<W) + ((LH+HL)<<H) + LL, 2W bits:
  - EXACT: out_p = F.
  - TRUNC: out_p = {F[2W-1:W], W'b0}.
  - ZONED: out_p[2W-1:W] = F[2W-1:W], so the high half is always exact. out_p[W-1:0] = (LLt + ((LHt + HLt) << H))[W-1:0], where Xt = X with its low TRUNC bits forced to 0 (LL uses LSB_TRUNC; LH and HL use MID_TRUNC). The sum is computed at ≥ W+2 bits and then truncated.
  - LSB_TRUNC = MID_TRUNC = 0 makes ZONED identical to EXACT.
- approx_count: +1 on each output transfer (out_valid && out_ready) whose mode is 1 or 2. Holds at 2^CW−1 once reached. No wrap.
- Simultaneous input and output transfer in the same cycle is legal; the full-throughput stream continues.

Decomposition:
- Shared package `zoned_mult_pkg`:
  - mode enum (MODE_EXACT = 0, MODE_ZONED = 1, MODE_TRUNC = 2, MODE_RSVD = 3).
  - function `trunc_low(x, n)`.
  - elaboration checks on W, LSB_TRUNC and MID_TRUNC.
- One sub-module: `zone_pp_gen`, the combinational H×H four-product generator instantiated in S2. Combine logic and pipeline control live in the top.

Test Plan:
- W=16, EXACT, a=0xFFFF, b=0xFFFF, out_ready=1 -> out_valid exactly 3 cycles later, out_p=0xFFFE0001, approx_count stays 0.
- ZONED, a=0xFFFF, b=0xFFFF -> out_p=0xFFFEFE00, out_mode=1, approx_count=1. Then ZONED a=0x1234, b=0x0010 -> out_p=0x00012340, approx_count=2.
- TRUNC, a=0xFFFF, b=0xFFFF -> out_p=0xFFFE0000. Mode 3 with the same operands -> out_p=0xFFFE0001, out_mode=0, count unchanged.
- Backpressure: stream 5 beats while out_ready is held low 4 cycles from the first out_valid -> in_ready=0 while the pipe is full, out_p held stable, all 5 results delivered in order with no loss or duplication.
- Reset mid-stream: assert rst with 3 beats in flight -> next cycle out_valid=0 and approx_count=0; none of the 3 results ever appears.
- Saturation with CW=2: deliver 5 ZONED results -> approx_count sequence 1, 2, 3, 3, 3.
